ghost_collision_resolver: RTL and testbench
===========================================

Name: ghost_collision_resolver

Overview:
- Producer side of the ghost-controller event interface.
- Compares Pac-Man's tile with the four ghost tiles and reads each ghost's current 4-bit state.
- Generates the per-ghost eaten and returned pulses, the Pac-Man-caught event, and the ghost-combo score.
- Sits between the movement/position logic and the ghost controller / score keeper.

Parameters:
- XW, 6, tile column width
- YW, 6, tile row width
- HOME_X, 13, ghost-house return tile column
- HOME_Y, 14, ghost-house return tile row
- FREEZE_CYCLES, 50000000, pause length after a ghost is eaten (must be >= 2)
- SCORE_W, 12, score output width

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_game_state  in  8  global game state; detection only when equal to GAME_PLAY (params.vh)
- i_ghost_reload  in  1  level/life restart pulse
- i_energizers_eaten  in  1  power pellet eaten pulse
- i_pac_x / i_pac_y  in  XW/YW  Pac-Man tile
- i_blinky_x, i_blinky_y, i_pinky_x, i_pinky_y, i_inky_x, i_inky_y, i_clyde_x, i_clyde_y  in  XW/YW  ghost tiles
- i_blinky_state, i_pinky_state, i_inky_state, i_clyde_state  in  4  ghost state (CHASE/SCATTER/FRIGHTENED/EATEN per params.vh)
- o_blinky_eaten, o_pinky_eaten, o_inky_eaten, o_clyde_eaten  out  1  one-cycle eaten pulse
- o_blinky_returned, o_pinky_returned, o_inky_returned, o_clyde_returned  out  1  one-cycle returned pulse
- o_pacman_caught  out  1  one-cycle death pulse
- o_freeze  out  1  high while movement must pause
- o_score_add  out  SCORE_W  points for the current eat
- o_score_valid  out  1  one-cycle qualifier for o_score_add

Behaviour:
- Reset: all outputs 0, FSM=IDLE, combo=0, freeze counter=0, returned-armed mask=4'b1111.
- All outputs are registered; a pulse appears 1 cycle after the sampled collision.
- Ghost g collides when (x,y) equals (pac_x,pac_y).
- FSM IDLE: outputs quiet. Go to ACTIVE when game_state==GAME_PLAY.
- FSM ACTIVE: go to IDLE when game_state!=GAME_PLAY.
- ACTIVE eat rule:
  - Among colliding FRIGHTENED ghosts, pick the lowest index (blinky>pinky>inky>clyde).
  - Pulse its eaten output, o_score_valid=1, o_score_add=200<<combo.
  - combo increments, saturating at 3, so 200/400/800/1600.
  - Load freeze counter, go to FREEZE.
  - Only one ghost is eaten per cycle. Remaining colliding frightened ghosts are resolved after FREEZE if they still overlap.
- ACTIVE death rule:
  - Applies only if no frightened collision this cycle and any colliding ghost is CHASE or SCATTER.
  - o_pacman_caught=1, go to CAUGHT.
  - Eating has priority over death.
- Ghosts in EATEN or any other state never collide.
- FSM FREEZE:
  - o_freeze=1; counter decrements each cycle; no collision detection.
  - At 0, return to ACTIVE.
- FSM CAUGHT:
  - o_freeze=1; no detection.
  - Holds until i_ghost_reload.
- Returned detection:
  - Runs in ACTIVE and FREEZE.
  - A ghost with state==EATEN on (HOME_X,HOME_Y) with its armed bit set: pulse returned, clear armed bit.
  - The armed bit sets again once that ghost's state != EATEN.
- i_energizers_eaten: combo=0 the same edge. If an eat also occurs that cycle, the eat uses combo=0 and combo becomes 1.
- i_ghost_reload (highest priority, any state):
  - combo=0, counter=0, armed=1111, FSM=IDLE, all pulses suppressed that cycle.
- Reset asserted mid-freeze: immediate return to reset values, no trailing pulses.

Optional Feature:
- Macro: GHOST_SWAP_DETECT_EN.
- Defined:
  - Registers previous-cycle Pac-Man and ghost tiles, updated every cycle.
  - A crossing also counts as a collision: pac_now==ghost_prev and ghost_now==pac_prev.
  - Same priority and eat/death rules apply.
- Undefined: same-tile compare only; no history registers.

Test Plan:
- Pinky FRIGHTENED at (5,5), Pac-Man moves to (5,5) in GAME_PLAY -> next cycle o_pinky_eaten=1, o_score_add=200, o_score_valid=1, o_freeze high for FREEZE_CYCLES cycles.
- Four frightened ghosts eaten in sequence, then one more frightened collision, no energizer between -> scores 200, 400, 800, 1600, 1600. New energizer, next eat -> 200.
- Blinky FRIGHTENED and Inky CHASE both on the Pac-Man tile -> o_blinky_eaten=1, no o_pacman_caught. After freeze, Inky still overlapping -> o_pacman_caught=1, o_freeze stays high until i_ghost_reload.
- Clyde EATEN, held on (13,14) for 10 cycles -> exactly one o_clyde_returned pulse. Leave EATEN, re-enter EATEN at home -> second pulse.
- i_ghost_reload during FREEZE with combo=2 -> o_freeze=0 next cycle, FSM IDLE, next eat scores 200.
- With GHOST_SWAP_DETECT_EN: Pac-Man (3,4)->(4,4) while a FRIGHTENED ghost moves (4,4)->(3,4) -> eaten pulse. Without the macro -> no pulse.

Source files
------------

// File: rtl/ghost_collision_resolver.sv
// ghost_collision_resolver: compares Pac-Man's tile with the four ghost tiles and
// produces eaten/returned pulses, the Pac-Man-caught event, freeze control and
// the ghost-combo score (200/400/800/1600).
// Optional feature: define GHOST_SWAP_DETECT_EN to also treat a tile swap
// (Pac-Man and a ghost crossing each other in one cycle) as a collision.
// Ghost index order everywhere: 0=blinky, 1=pinky, 2=inky, 3=clyde.
module ghost_collision_resolver #(
    parameter int           XW            = 6,
    parameter int           YW            = 6,
    parameter int           HOME_X        = 13,
    parameter int           HOME_Y        = 14,
    parameter int           FREEZE_CYCLES = 50000000,
    parameter int           SCORE_W       = 12,
    // Encodings shared with the rest of the game (params.vh)
    parameter logic [7:0]   GAME_PLAY     = 8'h01,
    parameter logic [3:0]   ST_CHASE      = 4'd0,
    parameter logic [3:0]   ST_SCATTER    = 4'd1,
    parameter logic [3:0]   ST_FRIGHTENED = 4'd2,
    parameter logic [3:0]   ST_EATEN      = 4'd3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_game_state,
    input  logic               i_ghost_reload,
    input  logic               i_energizers_eaten,
    input  logic [XW-1:0]      i_pac_x,
    input  logic [YW-1:0]      i_pac_y,
    input  logic [XW-1:0]      i_blinky_x,
    input  logic [YW-1:0]      i_blinky_y,
    input  logic [XW-1:0]      i_pinky_x,
    input  logic [YW-1:0]      i_pinky_y,
    input  logic [XW-1:0]      i_inky_x,
    input  logic [YW-1:0]      i_inky_y,
    input  logic [XW-1:0]      i_clyde_x,
    input  logic [YW-1:0]      i_clyde_y,
    input  logic [3:0]         i_blinky_state,
    input  logic [3:0]         i_pinky_state,
    input  logic [3:0]         i_inky_state,
    input  logic [3:0]         i_clyde_state,
    output logic               o_blinky_eaten,
    output logic               o_pinky_eaten,
    output logic               o_inky_eaten,
    output logic               o_clyde_eaten,
    output logic               o_blinky_returned,
    output logic               o_pinky_returned,
    output logic               o_inky_returned,
    output logic               o_clyde_returned,
    output logic               o_pacman_caught,
    output logic               o_freeze,
    output logic [SCORE_W-1:0] o_score_add,
    output logic               o_score_valid
);

    // Counter holds FREEZE_CYCLES-1 down to 0, so o_freeze stays high FREEZE_CYCLES cycles
    localparam int                 CNT_W      = $clog2(FREEZE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(FREEZE_CYCLES - 1);
    localparam logic [XW-1:0]      HOME_XV    = XW'(HOME_X);
    localparam logic [YW-1:0]      HOME_YV    = YW'(HOME_Y);
    localparam logic [SCORE_W-1:0] SCORE_BASE = SCORE_W'(200);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FREEZE, S_CAUGHT} state_t;

    state_t               state_q, state_d;
    logic [1:0]           combo_q, combo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           armed_q, armed_d;
    logic [3:0]           eaten_q, eaten_d;
    logic [3:0]           returned_q, returned_d;
    logic                 caught_q, caught_d;
    logic                 freeze_q, freeze_d;
    logic [SCORE_W-1:0]   score_add_q, score_add_d;
    logic                 score_valid_q, score_valid_d;

    logic [XW-1:0]        gx  [4];
    logic [YW-1:0]        gy  [4];
    logic [3:0]           gst [4];
    logic [3:0]           fr_mask, danger_mask, home_eaten_mask, not_eaten_mask;
    logic [3:0]           eat_pick;
    logic [1:0]           combo_base;
    logic [SCORE_W-1:0]   score_calc;

    assign gx[0] = i_blinky_x;   assign gy[0] = i_blinky_y;   assign gst[0] = i_blinky_state;
    assign gx[1] = i_pinky_x;    assign gy[1] = i_pinky_y;    assign gst[1] = i_pinky_state;
    assign gx[2] = i_inky_x;     assign gy[2] = i_inky_y;     assign gst[2] = i_inky_state;
    assign gx[3] = i_clyde_x;    assign gy[3] = i_clyde_y;    assign gst[3] = i_clyde_state;

`ifdef GHOST_SWAP_DETECT_EN
    logic [XW-1:0] pac_x_prev_q;
    logic [YW-1:0] pac_y_prev_q;

    // Previous-cycle Pac-Man tile for crossing detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pac_x_prev_q <= '0;
            pac_y_prev_q <= '0;
        end else begin
            pac_x_prev_q <= i_pac_x;
            pac_y_prev_q <= i_pac_y;
        end
    end
`endif

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ghost
            logic same_tile;
            logic collide;
            assign same_tile = (gx[gi] == i_pac_x) && (gy[gi] == i_pac_y);
`ifdef GHOST_SWAP_DETECT_EN
            logic [XW-1:0] gx_prev_q;
            logic [YW-1:0] gy_prev_q;

            // Previous-cycle ghost tile for crossing detection
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    gx_prev_q <= '0;
                    gy_prev_q <= '0;
                end else begin
                    gx_prev_q <= gx[gi];
                    gy_prev_q <= gy[gi];
                end
            end

            assign collide = same_tile ||
                             ((i_pac_x == gx_prev_q) && (i_pac_y == gy_prev_q) &&
                              (gx[gi] == pac_x_prev_q) && (gy[gi] == pac_y_prev_q));
`else
            assign collide = same_tile;
`endif
            assign fr_mask[gi]         = collide && (gst[gi] == ST_FRIGHTENED);
            assign danger_mask[gi]     = collide && ((gst[gi] == ST_CHASE) || (gst[gi] == ST_SCATTER));
            assign home_eaten_mask[gi] = (gst[gi] == ST_EATEN) && (gx[gi] == HOME_XV) && (gy[gi] == HOME_YV);
            assign not_eaten_mask[gi]  = (gst[gi] != ST_EATEN);
        end
    endgenerate

    // Lowest set bit wins: blinky before pinky before inky before clyde
    assign eat_pick   = fr_mask & (~fr_mask + 4'd1);
    // An energizer in the same cycle as an eat restarts the combo before scoring
    assign combo_base = i_energizers_eaten ? 2'd0 : combo_q;
    assign score_calc = SCORE_BASE << combo_base;

    // Next-state, pulse and score generation
    always_comb begin
        state_d       = state_q;
        combo_d       = combo_base;
        cnt_d         = cnt_q;
        armed_d       = armed_q | not_eaten_mask;
        eaten_d       = 4'b0000;
        returned_d    = 4'b0000;
        caught_d      = 1'b0;
        freeze_d      = 1'b0;
        score_add_d   = '0;
        score_valid_d = 1'b0;

        if ((state_q == S_ACTIVE) || (state_q == S_FREEZE)) begin
            returned_d = home_eaten_mask & armed_q;
            armed_d    = (armed_q & ~(home_eaten_mask & armed_q)) | not_eaten_mask;
        end

        case (state_q)
            S_IDLE: begin
                if (i_game_state == GAME_PLAY) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (i_game_state != GAME_PLAY) begin
                    state_d = S_IDLE;
                end else if (|fr_mask) begin
                    eaten_d       = eat_pick;
                    score_valid_d = 1'b1;
                    score_add_d   = score_calc;
                    combo_d       = (combo_base == 2'd3) ? 2'd3 : combo_base + 2'd1;
                    cnt_d         = CNT_LOAD;
                    freeze_d      = 1'b1;
                    state_d       = S_FREEZE;
                end else if (|danger_mask) begin
                    caught_d = 1'b1;
                    freeze_d = 1'b1;
                    state_d  = S_CAUGHT;
                end
            end
            S_FREEZE: begin
                if (cnt_q == '0) begin
                    state_d = S_ACTIVE;
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    freeze_d = 1'b1;
                end
            end
            S_CAUGHT: begin
                freeze_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Level/life restart overrides everything, including this cycle's pulses
        if (i_ghost_reload) begin
            state_d       = S_IDLE;
            combo_d       = 2'd0;
            cnt_d         = '0;
            armed_d       = 4'b1111;
            eaten_d       = 4'b0000;
            returned_d    = 4'b0000;
            caught_d      = 1'b0;
            freeze_d      = 1'b0;
            score_add_d   = '0;
            score_valid_d = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            combo_q       <= 2'd0;
            cnt_q         <= '0;
            armed_q       <= 4'b1111;
            eaten_q       <= 4'b0000;
            returned_q    <= 4'b0000;
            caught_q      <= 1'b0;
            freeze_q      <= 1'b0;
            score_add_q   <= '0;
            score_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            combo_q       <= combo_d;
            cnt_q         <= cnt_d;
            armed_q       <= armed_d;
            eaten_q       <= eaten_d;
            returned_q    <= returned_d;
            caught_q      <= caught_d;
            freeze_q      <= freeze_d;
            score_add_q   <= score_add_d;
            score_valid_q <= score_valid_d;
        end
    end

    assign o_blinky_eaten    = eaten_q[0];
    assign o_pinky_eaten     = eaten_q[1];
    assign o_inky_eaten      = eaten_q[2];
    assign o_clyde_eaten     = eaten_q[3];
    assign o_blinky_returned = returned_q[0];
    assign o_pinky_returned  = returned_q[1];
    assign o_inky_returned   = returned_q[2];
    assign o_clyde_returned  = returned_q[3];
    assign o_pacman_caught   = caught_q;
    assign o_freeze          = freeze_q;
    assign o_score_add       = score_add_q;
    assign o_score_valid     = score_valid_q;

endmodule

// File: tb/tb_ghost_collision_resolver.sv
// Scoreboard bench for ghost_collision_resolver: stimulus pushes expected event
// vectors, a negedge monitor pops one whenever the DUT shows any pulse.
module tb_ghost_collision_resolver;

    localparam int         F  = 6;
    localparam logic [7:0] GP = 8'h01;
    localparam logic [3:0] CH = 4'd0, SC = 4'd1, FR = 4'd2, EA = 4'd3;

    typedef struct packed {
        logic [3:0]  eaten;
        logic [3:0]  ret;
        logic        caught;
        logic        sv;
        logic [11:0] score;
    } ev_t;

    logic        clk, rst, reload, energ;
    logic [7:0]  game;
    logic [5:0]  pac_x, pac_y;
    logic [5:0]  gx [4];
    logic [5:0]  gy [4];
    logic [3:0]  gs [4];
    logic [3:0]  eaten, ret;
    logic        caught, freeze, sv;
    logic [11:0] score;

    int   checks = 0;
    int   passes = 0;
    ev_t  exp_q[$];
    ev_t  mon_act, mon_exp;

    ghost_collision_resolver #(
        .XW(6), .YW(6), .HOME_X(13), .HOME_Y(14), .FREEZE_CYCLES(F), .SCORE_W(12),
        .GAME_PLAY(GP), .ST_CHASE(CH), .ST_SCATTER(SC), .ST_FRIGHTENED(FR), .ST_EATEN(EA)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_game_state(game), .i_ghost_reload(reload),
        .i_energizers_eaten(energ), .i_pac_x(pac_x), .i_pac_y(pac_y),
        .i_blinky_x(gx[0]), .i_blinky_y(gy[0]), .i_pinky_x(gx[1]), .i_pinky_y(gy[1]),
        .i_inky_x(gx[2]), .i_inky_y(gy[2]), .i_clyde_x(gx[3]), .i_clyde_y(gy[3]),
        .i_blinky_state(gs[0]), .i_pinky_state(gs[1]), .i_inky_state(gs[2]), .i_clyde_state(gs[3]),
        .o_blinky_eaten(eaten[0]), .o_pinky_eaten(eaten[1]), .o_inky_eaten(eaten[2]), .o_clyde_eaten(eaten[3]),
        .o_blinky_returned(ret[0]), .o_pinky_returned(ret[1]), .o_inky_returned(ret[2]), .o_clyde_returned(ret[3]),
        .o_pacman_caught(caught), .o_freeze(freeze), .o_score_add(score), .o_score_valid(sv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every presented event must match the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            mon_act = '{eaten: eaten, ret: ret, caught: caught, sv: sv, score: score};
            if ((eaten != 4'b0) || (ret != 4'b0) || caught || sv) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL event: unexpected eaten=%b ret=%b caught=%b sv=%b score=%0d, none expected",
                             eaten, ret, caught, sv, score);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp)
                        $display("FAIL event: got eaten=%b ret=%b caught=%b sv=%b score=%0d, expected eaten=%b ret=%b caught=%b sv=%b score=%0d",
                                 eaten, ret, caught, sv, score,
                                 mon_exp.eaten, mon_exp.ret, mon_exp.caught, mon_exp.sv, mon_exp.score);
                    else begin
                        passes++;
                        $display("event ok: eaten=%b ret=%b caught=%b score=%0d", eaten, ret, caught, score);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else begin
            passes++;
            $display("check %s ok: %0d", name, act);
        end
    endtask

    task automatic push(input logic [3:0] e, input logic [3:0] r, input logic c, input logic v, input logic [11:0] s);
        ev_t ev;
        ev = '{eaten: e, ret: r, caught: c, sv: v, score: s};
        exp_q.push_back(ev);
    endtask

    task automatic set_ghost(input int g, input logic [5:0] x, input logic [5:0] y, input logic [3:0] st);
        gx[g] = x; gy[g] = y; gs[g] = st;
    endtask

    task automatic park(input int g);
        set_ghost(g, 6'(20 + g), 6'd1, CH);
    endtask

    task automatic pac_away();
        pac_x = 6'd1; pac_y = 6'd20;
    endtask

    // Counts consecutive cycles with o_freeze high, then realigns to posedge+1
    task automatic wait_freeze(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!freeze) break;
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic eat(input int g, input logic [5:0] x, input logic [5:0] y,
                       input logic energize, input logic [11:0] s);
        int n;
        set_ghost(g, x, y, FR);
        tick();
        push(4'(1 << g), 4'b0, 1'b0, 1'b1, s);
        pac_x = x; pac_y = y; energ = energize;
        tick();
        energ = 1'b0;
        pac_away();
        park(g);
        wait_freeze(n);
        check("freeze_len", n, F);
    endtask

    initial begin
        int n;
        rst = 1'b1; reload = 1'b0; energ = 1'b0; game = GP;
        pac_away();
        for (int g = 0; g < 4; g++) park(g);
        tick(); tick();
        check("reset_outputs", {20'd0, eaten, ret, caught, freeze, sv, score}, 0);
        rst = 1'b0;
        tick();

        // Single eat: pinky at (5,5)
        eat(1, 6'd5, 6'd5, 1'b0, 12'd200);

        // Combo run after an energizer, saturation, energizer coinciding with an eat
        energ = 1'b1; tick(); energ = 1'b0;
        eat(0, 6'd5, 6'd5, 1'b0, 12'd200);
        eat(1, 6'd6, 6'd5, 1'b0, 12'd400);
        eat(2, 6'd7, 6'd5, 1'b0, 12'd800);
        eat(3, 6'd8, 6'd5, 1'b0, 12'd1600);
        eat(0, 6'd9, 6'd5, 1'b0, 12'd1600);
        eat(1, 6'd10, 6'd5, 1'b1, 12'd200);
        eat(2, 6'd11, 6'd5, 1'b0, 12'd400);

        // Eat beats death; the remaining chaser catches Pac-Man after the freeze
        set_ghost(0, 6'd8, 6'd8, FR);
        set_ghost(2, 6'd8, 6'd8, CH);
        tick();
        push(4'b0001, 4'b0, 1'b0, 1'b1, 12'd800);
        push(4'b0000, 4'b0, 1'b1, 1'b0, 12'd0);
        pac_x = 6'd8; pac_y = 6'd8;
        tick();
        set_ghost(0, 6'd8, 6'd8, EA);
        wait_freeze(n);
        check("freeze_len_pre_caught", n, F);
        check("caught_pulse", caught, 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (freeze) n++;
            tick();
        end
        check("caught_hold", n, 20);
        pac_away(); park(0); park(2);
        reload = 1'b1; tick(); reload = 1'b0;
        check("reload_unfreeze_caught", freeze, 0);

        // Reload in the middle of a freeze with combo=2
        eat(0, 6'd5, 6'd6, 1'b0, 12'd200);
        set_ghost(1, 6'd6, 6'd6, FR);
        tick();
        push(4'b0010, 4'b0, 1'b0, 1'b1, 12'd400);
        pac_x = 6'd6; pac_y = 6'd6;
        tick();
        pac_away(); park(1);
        tick(); tick();
        reload = 1'b1; tick(); reload = 1'b0;
        check("reload_unfreeze", freeze, 0);
        eat(3, 6'd7, 6'd6, 1'b0, 12'd200);

        // Asynchronous reset mid-freeze
        set_ghost(2, 6'd5, 6'd9, FR);
        tick();
        push(4'b0100, 4'b0, 1'b0, 1'b1, 12'd400);
        pac_x = 6'd5; pac_y = 6'd9;
        tick();
        pac_away(); park(2);
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_freeze", {freeze, sv, eaten}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Clyde returns home: one pulse while held, re-armed after leaving EATEN
        set_ghost(3, 6'd13, 6'd14, EA);
        push(4'b0, 4'b1000, 1'b0, 1'b0, 12'd0);
        tick();
        repeat (10) tick();
        set_ghost(3, 6'd13, 6'd14, CH);
        tick();
        push(4'b0, 4'b1000, 1'b0, 1'b0, 12'd0);
        set_ghost(3, 6'd13, 6'd14, EA);
        tick(); tick();
        park(3);
        tick();

        // No detection outside GAME_PLAY, first play cycle only arms the FSM
        game = 8'h00;
        tick();
        set_ghost(0, 6'd6, 6'd6, FR);
        pac_x = 6'd6; pac_y = 6'd6;
        tick(); tick(); tick();
        check("idle_no_freeze", freeze, 0);
        push(4'b0001, 4'b0, 1'b0, 1'b1, 12'd200);
        game = GP;
        tick(); tick();
        pac_away(); park(0);
        wait_freeze(n);
        check("freeze_len_after_idle", n, F);

        // Tile swap between Pac-Man and pinky
        set_ghost(1, 6'd4, 6'd4, FR);
        pac_x = 6'd3; pac_y = 6'd4;
        tick(); tick();
`ifdef GHOST_SWAP_DETECT_EN
        push(4'b0010, 4'b0, 1'b0, 1'b1, 12'd400);
`endif
        pac_x = 6'd4; pac_y = 6'd4;
        set_ghost(1, 6'd3, 6'd4, FR);
        tick();
`ifdef GHOST_SWAP_DETECT_EN
        check("swap_eaten", eaten[1], 1);
`else
        check("swap_eaten", eaten[1], 0);
`endif
        pac_away(); park(1);
        wait_freeze(n);
        repeat (5) tick();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
